fft_rot_sequencer: RTL and testbench
====================================

FFT_ROT_SEQUENCER -- requirements
Module: fft_rot_sequencer

Interface
REQ-001 SHALL have parameter: N_STAGES, default 5, number of rotation stages issued per run (legal 1..5).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: clr_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  run request; sampled only in IDLE.
REQ-005 SHALL have port: ready  input  1  downstream accepts addr this cycle.
REQ-006 SHALL have port: rot_q  input  5  registered output of the external 5-bit rotate-left-by-S unit.
REQ-007 SHALL have port: rot_d  output  5  index presented to the rotate unit d input.
REQ-008 SHALL have port: rot_s  output  3  rotation amount presented to the rotate unit s input (0..4).
REQ-009 SHALL have port: rot_clr  output  1  active-high clear to the rotate unit; equals ~clr_n.
REQ-010 SHALL have port: addr  output  5  rotated address; combinational pass-through of rot_q.
REQ-011 SHALL have port: addr_vld  output  1  addr/addr_stage/addr_last valid.
REQ-012 SHALL have port: addr_stage  output  3  stage tag of addr.
REQ-013 SHALL have port: addr_last  output  1  addr is the final item of the run.
REQ-014 SHALL have port: busy  output  1  high in RUN and DRAIN.
REQ-015 SHALL have port: done  output  1  one-cycle pulse at run completion.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on issue of final item; DRAIN->IDLE when no unaccepted item remains.
REQ-017 SHALL hold registers idx (5 bit) and stg (3 bit), both cleared to 0 on the IDLE->RUN transition.
REQ-018 SHALL define fire = (state==RUN) && (!addr_vld || ready).
REQ-019 On fire, SHALL issue pair (idx, stg): rot_d=idx, rot_s=stg in that same cycle, and record it in last_d/last_s.
REQ-020 When not firing, SHALL drive rot_d=last_d and rot_s=last_s, so rot_q stays constant while stalled.
REQ-021 On fire, SHALL increment idx mod 32; when idx==31, SHALL wrap idx to 0 and increment stg.
REQ-022 Final item SHALL be idx==31 and stg==N_STAGES-1; a run SHALL issue exactly N_STAGES*32 items in order stage-major, index-minor.
REQ-023 addr_vld SHALL set at the edge ending a fire cycle (1-cycle rotate latency), and clear at an edge where ready==1 and no fire occurs.
REQ-024 addr_stage/addr_last SHALL register the stage and final flag of the issued pair on fire, and hold while stalled.
REQ-025 addr SHALL equal the issued index rotated left by its stage (e.g. d=00001, s=2 -> 00100).
REQ-026 Ready low with addr_vld high SHALL hold addr, addr_stage, addr_last, idx and stg unchanged.
REQ-027 Zero-bubble throughput: with ready held 1, SHALL issue one item per cycle.
REQ-028 DRAIN SHALL exit when addr_vld==0, or when addr_vld==1 and ready==1; done SHALL pulse in the first IDLE cycle after exit.
REQ-029 start during RUN/DRAIN SHALL be ignored (no restart, no queueing); start in the done cycle SHALL begin a new run.
REQ-030 rot_s SHALL never exceed 4.

Reset
REQ-031 clr_n low SHALL asynchronously force state=IDLE, idx=0, stg=0, last_d=0, last_s=0, addr_vld=0, addr_stage=0, addr_last=0, done=0, busy=0, and rot_clr=1.
REQ-032 Reset asserted mid-run SHALL abandon the run with no done pulse; after release, the block SHALL wait in IDLE for start.
REQ-033 After clr_n deasserts, the first issue SHALL occur no earlier than the cycle after start is sampled.

Verification
REQ-034 Directed test, stall-free run: N_STAGES=5, ready=1, one start pulse -> 160 consecutive addr_vld cycles, first addr=0 (stg 0); item (idx=1, stg=2) gives addr=00100; item (idx=31, stg=4) has addr_last=1; done pulses once, one cycle after the final accepted item.
REQ-035 Directed test, backpressure: deassert ready for 3 cycles while addr_vld=1 at (idx=5, stg=1), addr=01010 -> addr, addr_stage and idx held for 3 cycles; no item is dropped or duplicated in the full scoreboard.
REQ-036 Directed test, stall on last item: ready=0 when addr_last=1 -> block stays in DRAIN with busy=1; ready=1 -> done pulses the next cycle.
REQ-037 Directed test, ignored start: pulse start while busy -> item count remains exactly N_STAGES*32 and done pulses once.
REQ-038 Directed test, reset mid-run: clr_n low at item 40 -> all outputs zero and rot_clr=1 immediately (asynchronous); no done pulse; a new start then yields a full sequence beginning at addr=0.
REQ-039 Directed test, N_STAGES=1: start -> 32 items, all addr_stage=0, addr==index; done follows.

Source files
------------

// File: rtl/fft_rot_sequencer.sv
// rtl/fft_rot_sequencer.sv - stage-major index sequencer driving an external registered rotate-left unit
module fft_rot_sequencer #(
  parameter int N_STAGES = 5
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       ready,
  input  logic [4:0] rot_q,
  output logic [4:0] rot_d,
  output logic [2:0] rot_s,
  output logic       rot_clr,
  output logic [4:0] addr,
  output logic       addr_vld,
  output logic [2:0] addr_stage,
  output logic       addr_last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam logic [2:0] LAST_STG = 3'(N_STAGES - 1);

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [2:0] stg_q, stg_d;
  logic [4:0] last_d_q, last_d_d;
  logic [2:0] last_s_q, last_s_d;
  logic       vld_q, vld_d;
  logic [2:0] stage_q, stage_d;
  logic       lastf_q, lastf_d;
  logic       done_q, done_d;

  logic fire;
  logic final_item;

  // Issue whenever running and the output slot is empty or being drained this cycle.
  assign fire       = (state_q == RUN) && (!vld_q || ready);
  assign final_item = (idx_q == 5'd31) && (stg_q == LAST_STG);

  // While stalled the rotate unit is re-fed the last pair so its registered output holds.
  assign rot_d      = fire ? idx_q : last_d_q;
  assign rot_s      = fire ? stg_q : last_s_q;
  assign rot_clr    = ~clr_n;
  assign addr       = rot_q;
  assign addr_vld   = vld_q;
  assign addr_stage = stage_q;
  assign addr_last  = lastf_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  // Next-state logic: run control, issue counters and output slot bookkeeping.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stg_d    = stg_q;
    last_d_d = last_d_q;
    last_s_d = last_s_q;
    stage_d  = stage_q;
    lastf_d  = lastf_q;
    done_d   = 1'b0;
    vld_d    = vld_q;

    if (fire) begin
      vld_d = 1'b1;
    end else if (ready) begin
      vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 5'd0;
          stg_d   = 3'd0;
        end
      end
      RUN: begin
        if (fire) begin
          last_d_d = idx_q;
          last_s_d = stg_q;
          stage_d  = stg_q;
          lastf_d  = final_item;
          idx_d    = idx_q + 5'd1;
          if (idx_q == 5'd31) begin
            stg_d = stg_q + 3'd1;
          end
          if (final_item) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!vld_q || ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous clear of the whole run context.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      idx_q    <= 5'd0;
      stg_q    <= 3'd0;
      last_d_q <= 5'd0;
      last_s_q <= 3'd0;
      vld_q    <= 1'b0;
      stage_q  <= 3'd0;
      lastf_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      stg_q    <= stg_d;
      last_d_q <= last_d_d;
      last_s_q <= last_s_d;
      vld_q    <= vld_d;
      stage_q  <= stage_d;
      lastf_q  <= lastf_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_fft_rot_sequencer.sv
// tb/tb_fft_rot_sequencer.sv - scoreboard bench for fft_rot_sequencer with 5-stage and 1-stage instances
module tb_fft_rot_sequencer;

  typedef struct {
    int addr;
    int stage;
    int last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_n;
  logic       start5, ready5, start1, ready1;
  logic [4:0] rot_q5 = '0, rot_d5, addr5;
  logic [2:0] rot_s5, stage5;
  logic       rot_clr5, vld5, last5, busy5, done5;
  logic [4:0] rot_q1 = '0, rot_d1, addr1;
  logic [2:0] rot_s1, stage1;
  logic       rot_clr1, vld1, last1, busy1, done1;

  exp_t q5[$];
  exp_t q1[$];
  int n_checks = 0;
  int n_errors = 0;
  int items5 = 0, items1 = 0, dones5 = 0, dones1 = 0;

  fft_rot_sequencer #(.N_STAGES(5)) u_dut5 (
    .clk(clk), .clr_n(clr_n), .start(start5), .ready(ready5),
    .rot_q(rot_q5), .rot_d(rot_d5), .rot_s(rot_s5), .rot_clr(rot_clr5),
    .addr(addr5), .addr_vld(vld5), .addr_stage(stage5), .addr_last(last5),
    .busy(busy5), .done(done5)
  );

  fft_rot_sequencer #(.N_STAGES(1)) u_dut1 (
    .clk(clk), .clr_n(clr_n), .start(start1), .ready(ready1),
    .rot_q(rot_q1), .rot_d(rot_d1), .rot_s(rot_s1), .rot_clr(rot_clr1),
    .addr(addr1), .addr_vld(vld1), .addr_stage(stage1), .addr_last(last1),
    .busy(busy1), .done(done1)
  );

  // External registered rotate-left unit with asynchronous clear
  function automatic logic [4:0] rot_unit(input logic [4:0] d, input logic [2:0] s);
    logic [9:0] w;
    w = {d, d} << s;
    return w[9:5];
  endfunction

  always @(posedge clk or posedge rot_clr5)
    if (rot_clr5) rot_q5 <= '0;
    else          rot_q5 <= rot_unit(rot_d5, rot_s5);

  always @(posedge clk or posedge rot_clr1)
    if (rot_clr1) rot_q1 <= '0;
    else          rot_q1 <= rot_unit(rot_d1, rot_s1);

  function automatic int ref_rot(input int i, input int s);
    return ((i << s) | (i >> (5 - s))) & 31;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_run(input int n);
    exp_t e;
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < 32; i++) begin
        e.addr  = ref_rot(i, s);
        e.stage = s;
        e.last  = (s == n - 1 && i == 31) ? 1 : 0;
        if (n == 5) q5.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  task automatic pulse(input int which);
    if (which == 5) start5 = 1'b1; else start1 = 1'b1;
    @(posedge clk) #1;
    start5 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle5(input int budget);
    int c;
    c = 0;
    while (busy5 && c < budget) begin
      ready5 = ($urandom_range(0, 3) != 0);
      @(posedge clk) #1;
      c++;
    end
    chk("idle5 timeout", busy5, 0);
    ready5 = 1'b1;
    @(negedge clk);
    @(posedge clk) #1;
  endtask

  // Monitor for the 5-stage instance: pop and compare on every accepted item
  always @(negedge clk) begin
    exp_t e;
    if (clr_n) begin
      if (vld5 && ready5) begin
        if (q5.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra5: got item addr %0d stage %0d, expected no item", addr5, stage5);
        end else begin
          e = q5.pop_front();
          chk("addr5", addr5, e.addr);
          chk("stage5", stage5, e.stage);
          chk("last5", last5, e.last);
        end
        items5++;
      end
      if (done5) dones5++;
      if (rot_s5 > 3'd4) begin
        n_checks++;
        n_errors++;
        $display("FAIL rot_s5 range: got %0d expected <= 4", rot_s5);
      end
    end
  end

  // Monitor for the 1-stage instance
  always @(negedge clk) begin
    exp_t e;
    if (clr_n) begin
      if (vld1 && ready1) begin
        if (q1.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra1: got item addr %0d stage %0d, expected no item", addr1, stage1);
        end else begin
          e = q1.pop_front();
          chk("addr1", addr1, e.addr);
          chk("stage1", stage1, e.stage);
          chk("last1", last1, e.last);
        end
        items1++;
      end
      if (done1) dones1++;
    end
  end

  initial begin
    int c, run_len, base_i, base_d, held, target;
    clr_n = 1'b0; start5 = 1'b0; ready5 = 1'b1; start1 = 1'b0; ready1 = 1'b1;

    // Reset state
    #12;
    chk("rst vld", vld5, 0);
    chk("rst busy", busy5, 0);
    chk("rst done", done5, 0);
    chk("rst rot_clr", rot_clr5, 1);
    chk("rst addr", addr5, 0);
    chk("rst rot_d", rot_d5, 0);
    chk("rst rot_s", rot_s5, 0);
    chk("rst stage", stage5, 0);
    chk("rst last", last5, 0);
    @(posedge clk) #1;
    clr_n = 1'b1;
    repeat (3) @(posedge clk) #1;
    chk("post-rst rot_clr", rot_clr5, 0);
    chk("post-rst idle vld", vld5, 0);
    chk("post-rst idle busy", busy5, 0);

    // Stall-free run
    push_run(5);
    base_d = dones5;
    base_i = items5;
    pulse(5);
    c = 0;
    while (!vld5 && c < 10) begin @(posedge clk) #1; c++; end
    chk("first issue latency", c, 1);
    run_len = 0;
    while (vld5 && run_len < 400) begin run_len++; @(posedge clk) #1; end
    chk("consecutive vld", run_len, 160);
    chk("done after last", done5, 1);
    @(posedge clk) #1;
    chk("stallfree idle", busy5, 0);
    chk("stallfree items", items5 - base_i, 160);
    chk("stallfree dones", dones5 - base_d, 1);
    chk("stallfree queue", q5.size(), 0);

    // Random backpressure, held item (idx 5, stage 1), ignored starts
    push_run(5);
    base_d = dones5;
    base_i = items5;
    held = 0;
    pulse(5);
    c = 0;
    while (busy5 && c < 3000) begin
      if (!held && vld5 && stage5 == 3'd1 && addr5 == 5'b01010) begin
        ready5 = 1'b0;
        start5 = 1'b0;
        held = 1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("hold addr", addr5, 5'b01010);
          chk("hold stage", stage5, 1);
          chk("hold rot_d", rot_d5, 5);
          chk("hold vld", vld5, 1);
          @(posedge clk) #1;
        end
        ready5 = 1'b1;
      end else begin
        ready5 = ($urandom_range(0, 3) != 0);
        start5 = busy5 && ($urandom_range(0, 7) == 0);
        @(posedge clk) #1;
      end
      c++;
    end
    start5 = 1'b0;
    ready5 = 1'b1;
    chk("bp timeout", busy5, 0);
    @(negedge clk);
    @(posedge clk) #1;
    chk("bp stall hit", held, 1);
    chk("bp items", items5 - base_i, 160);
    chk("bp dones", dones5 - base_d, 1);
    chk("bp queue", q5.size(), 0);
    chk("bp no restart", busy5, 0);

    // Stall on the last item
    push_run(5);
    base_d = dones5;
    pulse(5);
    c = 0;
    while (!(vld5 && last5) && c < 3000) begin
      ready5 = ($urandom_range(0, 3) != 0);
      @(posedge clk) #1;
      c++;
    end
    chk("reach last", vld5 && last5, 1);
    ready5 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drain busy", busy5, 1);
      chk("drain vld", vld5, 1);
      chk("drain no done", done5, 0);
      @(posedge clk) #1;
    end
    ready5 = 1'b1;
    @(posedge clk) #1;
    chk("drain done", done5, 1);
    chk("drain exit", busy5, 0);
    @(posedge clk) #1;
    chk("drain done once", dones5 - base_d, 1);
    chk("drain queue", q5.size(), 0);

    // Reset mid-run
    push_run(5);
    base_d = dones5;
    target = items5 + 40;
    pulse(5);
    c = 0;
    while (items5 < target && c < 3000) begin
      ready5 = ($urandom_range(0, 3) != 0);
      @(posedge clk) #1;
      c++;
    end
    chk("reach item 40", items5 >= target, 1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("mid rst vld", vld5, 0);
    chk("mid rst addr", addr5, 0);
    chk("mid rst stage", stage5, 0);
    chk("mid rst last", last5, 0);
    chk("mid rst busy", busy5, 0);
    chk("mid rst done", done5, 0);
    chk("mid rst rot_clr", rot_clr5, 1);
    chk("mid rst rot_d", rot_d5, 0);
    q5.delete();
    ready5 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    repeat (5) @(posedge clk) #1;
    chk("after rst idle", busy5, 0);
    chk("after rst no vld", vld5, 0);
    chk("after rst no done", dones5 - base_d, 0);
    push_run(5);
    base_i = items5;
    pulse(5);
    wait_idle5(3000);
    chk("rerun items", items5 - base_i, 160);
    chk("rerun dones", dones5 - base_d, 1);
    chk("rerun queue", q5.size(), 0);

    // Single-stage instance
    push_run(1);
    pulse(1);
    c = 0;
    while (busy1 && c < 1000) begin
      ready1 = ($urandom_range(0, 3) != 0);
      @(posedge clk) #1;
      c++;
    end
    ready1 = 1'b1;
    chk("n1 timeout", busy1, 0);
    @(negedge clk);
    @(posedge clk) #1;
    chk("n1 items", items1, 32);
    chk("n1 dones", dones1, 1);
    chk("n1 queue", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
